// File: rtl/hd_beat_if.sv
// Interface between the front-panel/decoder logic and the hd_beat_seq sequencer.
// The master modport is the controller side: it drives the requests and
// decoder strobes and watches the beats and interrupt state. The slave
// modport is the sequencer itself. Signal names follow the HD-CPU schematic.
interface hd_beat_if;
    // Controller requests and decoder strobes, sampled on the falling edge of T3
    logic       QD;        // console start pulse
    logic       SHORT;     // end machine cycle after W1
    logic       LONG;      // extend machine cycle to W3
    logic       STOP;      // halt after the current beat
    logic       RUN_MODE;  // console in program-execution mode
    logic       IRET;      // IRET in the current instruction
    logic       EI_SET;    // enable-interrupt pulse
    logic       EI_CLR;    // disable-interrupt pulse
    logic       PULSE;     // asynchronous interrupt request level

    // Sequencer state, all registered
    logic [3:1] W;         // one-hot beat
    logic       RUN;       // sequencer advancing
    logic       EI;        // interrupt enable
    logic       INT_PEND;  // request latched, not yet accepted
    logic       INTA;      // one-cycle acknowledge
    logic [2:0] INT_STEP;  // 0 normal, 1..3 save, 4..5 restore

    modport master (
        output QD, SHORT, LONG, STOP, RUN_MODE, IRET, EI_SET, EI_CLR, PULSE,
        input  W, RUN, EI, INT_PEND, INTA, INT_STEP
    );

    modport slave (
        input  QD, SHORT, LONG, STOP, RUN_MODE, IRET, EI_SET, EI_CLR, PULSE,
        output W, RUN, EI, INT_PEND, INTA, INT_STEP
    );
endinterface

// File: rtl/hd_beat_seq.sv
// hd_beat_seq: beat sequencer and interrupt-step scheduler for the HD-CPU
// hardwired controller.
//
// Generates the one-hot W[3:1] machine-cycle beats under SHORT/LONG/STOP/QD
// control and, when the macro HD_BEAT_INT_EN is defined, latches external
// interrupt requests and steps the controller through the save (1..3) and
// restore (4..5) sequences. Without HD_BEAT_INT_EN the interrupt outputs are
// tied off (EI=1, everything else 0) and the PULSE synchroniser is absent.
//
// All state changes on the falling edge of T3; CLR is an asynchronous
// active-low reset. Every output comes straight from a flop.
module hd_beat_seq #(
    parameter int SYNC_STAGES = 2   // PULSE synchroniser depth, 2..3
) (
    input  logic       T3,
    input  logic       CLR,
    hd_beat_if.slave   bus
);

    localparam logic [3:1] BEAT_W1 = 3'b001;
    localparam logic [3:1] BEAT_W2 = 3'b010;
    localparam logic [3:1] BEAT_W3 = 3'b100;

    // ------------------------------------------------------------------
    // Beat sequencer
    // ------------------------------------------------------------------
    logic [3:1] w_q;
    logic [3:1] w_d;
    logic [3:1] w_adv;      // beat that follows w_q if the sequencer advances
    logic       run_q;
    logic       run_d;

    // Successor beat; an illegal (non one-hot) value recovers to W1
    always_comb begin
        w_adv = BEAT_W1;
        case (w_q)
            BEAT_W1: w_adv = bus.SHORT ? BEAT_W1 : BEAT_W2;
            BEAT_W2: w_adv = bus.LONG  ? BEAT_W3 : BEAT_W1;
            BEAT_W3: w_adv = BEAT_W1;
            default: w_adv = BEAT_W1;
        endcase
    end

    // Advance when running (STOP finishes the beat then halts); QD only starts
    always_comb begin
        w_d   = w_q;
        run_d = run_q;
        if (run_q) begin
            w_d = w_adv;
            if (bus.STOP) begin
                run_d = 1'b0;
            end
        end else if (bus.QD) begin
            run_d = 1'b1;
        end
    end

    // Beat and run state registers
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            w_q   <= BEAT_W1;
            run_q <= 1'b0;
        end else begin
            w_q   <= w_d;
            run_q <= run_d;
        end
    end

    assign bus.W   = w_q;
    assign bus.RUN = run_q;

`ifdef HD_BEAT_INT_EN
    // ------------------------------------------------------------------
    // Interrupt logic
    // ------------------------------------------------------------------
    // Depth outside 2..3 is clamped rather than rejected
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 :
                            (SYNC_STAGES > 3) ? 3 : SYNC_STAGES;

    logic [SYNC_N-1:0] sync_q;       // PULSE synchroniser chain
    logic              sync_prev_q;  // previous synchronised level
    logic              pulse_rise;
    logic              boundary;
    logic              accept;

    logic              ei_q;
    logic              ei_d;
    logic              int_pend_q;
    logic              int_pend_d;
    logic              inta_q;
    logic              inta_d;
    logic [2:0]        int_step_q;
    logic [2:0]        int_step_d;

    // Synchroniser chain: stage 0 samples PULSE, later stages shift it along
    for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            // First stage captures the asynchronous request
            always_ff @(negedge T3 or negedge CLR) begin
                if (!CLR) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= bus.PULSE;
                end
            end
        end else begin : g_next
            // Later stages resolve metastability
            always_ff @(negedge T3 or negedge CLR) begin
                if (!CLR) begin
                    sync_q[gi] <= 1'b0;
                end else begin
                    sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    end

    // Edge detector on the synchronised level
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            sync_prev_q <= 1'b0;
        end else begin
            sync_prev_q <= sync_q[SYNC_N-1];
        end
    end

    assign pulse_rise = sync_q[SYNC_N-1] & ~sync_prev_q;

    // An instruction boundary is an advancing edge that lands on W1 in run mode
    assign boundary = run_q & (w_adv == BEAT_W1) & bus.RUN_MODE;
    assign accept   = boundary & int_pend_q & ei_q & (int_step_q == 3'd0);

    // Interrupt enable, pending flag, acknowledge and step scheduling
    always_comb begin
        ei_d       = ei_q;
        int_pend_d = int_pend_q;
        int_step_d = int_step_q;
        inta_d     = accept;

        // Software enable/disable; disable wins when both strobe together
        if (bus.EI_SET) begin
            ei_d = 1'b1;
        end
        if (bus.EI_CLR) begin
            ei_d = 1'b0;
        end

        // A fresh request is latched even if an older one is accepted now
        if (accept) begin
            int_pend_d = 1'b0;
        end
        if (pulse_rise) begin
            int_pend_d = 1'b1;
        end

        if (boundary) begin
            if (accept) begin
                // Acceptance outranks a simultaneous IRET, which is dropped
                int_step_d = 3'd1;
                ei_d       = 1'b0;
            end else begin
                case (int_step_q)
                    3'd0:    int_step_d = bus.IRET ? 3'd4 : 3'd0;
                    3'd1:    int_step_d = 3'd2;
                    3'd2:    int_step_d = 3'd3;
                    3'd3:    int_step_d = 3'd0;
                    3'd4:    int_step_d = 3'd5;
                    3'd5: begin
                        int_step_d = 3'd0;
                        ei_d       = 1'b1;   // restore complete, re-enable
                    end
                    default: int_step_d = 3'd0;   // 6,7 unreachable: recover
                endcase
            end
        end
    end

    // Interrupt state registers
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            ei_q       <= 1'b1;
            int_pend_q <= 1'b0;
            inta_q     <= 1'b0;
            int_step_q <= 3'd0;
        end else begin
            ei_q       <= ei_d;
            int_pend_q <= int_pend_d;
            inta_q     <= inta_d;
            int_step_q <= int_step_d;
        end
    end

    assign bus.EI       = ei_q;
    assign bus.INT_PEND = int_pend_q;
    assign bus.INTA     = inta_q;
    assign bus.INT_STEP = int_step_q;
`else
    // ------------------------------------------------------------------
    // Interrupts disabled: constant outputs, strobes ignored
    // ------------------------------------------------------------------
    logic        int_inputs_unused;
    logic [31:0] sync_cfg_unused;

    assign int_inputs_unused = ^{bus.PULSE, bus.IRET, bus.EI_SET,
                                 bus.EI_CLR, bus.RUN_MODE};
    assign sync_cfg_unused   = SYNC_STAGES;

    assign bus.EI       = 1'b1;
    assign bus.INT_PEND = 1'b0;
    assign bus.INTA     = 1'b0;
    assign bus.INT_STEP = 3'd0;
`endif

endmodule

// File: tb/tb_hd_beat_seq.sv
// Testbench for hd_beat_seq: table-driven beat sequencing vectors followed by
// hand-written interrupt / reset sequences. Works for both builds, with or
// without HD_BEAT_INT_EN.
module tb_hd_beat_seq;

    logic T3  = 1'b1;
    logic CLR = 1'b0;

    hd_beat_if bus ();

    hd_beat_seq #(.SYNC_STAGES(2)) dut (
        .T3  (T3),
        .CLR (CLR),
        .bus (bus)
    );

    // Active edge is the falling edge at 5, 15, 25 ...
    always #5 T3 = ~T3;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       qd;
        logic       shrt;
        logic       lng;
        logic       stp;
        logic [2:0] w;
        logic       run;
        string      name;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] w, input logic run,
                           input logic ei, input logic pend, input logic inta,
                           input logic [2:0] step);
        chk({tag, " W"},        {29'd0, bus.W},        {29'd0, w});
        chk({tag, " RUN"},      {31'd0, bus.RUN},      {31'd0, run});
        chk({tag, " EI"},       {31'd0, bus.EI},       {31'd0, ei});
        chk({tag, " INT_PEND"}, {31'd0, bus.INT_PEND}, {31'd0, pend});
        chk({tag, " INTA"},     {31'd0, bus.INTA},     {31'd0, inta});
        chk({tag, " INT_STEP"}, {29'd0, bus.INT_STEP}, {29'd0, step});
        $display("[TB] %s: W=%b RUN=%b EI=%b PEND=%b INTA=%b STEP=%0d",
                 tag, bus.W, bus.RUN, bus.EI, bus.INT_PEND, bus.INTA, bus.INT_STEP);
    endtask

    // One active (falling) edge, then sample mid-cycle on the rising edge
    task automatic tick();
        @(negedge T3);
        @(posedge T3);
    endtask

    task automatic clear_in();
        bus.QD       = 1'b0;
        bus.SHORT    = 1'b0;
        bus.LONG     = 1'b0;
        bus.STOP     = 1'b0;
        bus.RUN_MODE = 1'b1;
        bus.IRET     = 1'b0;
        bus.EI_SET   = 1'b0;
        bus.EI_CLR   = 1'b0;
        bus.PULSE    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //                qd shrt lng stp  w       run  name
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, "qd_start"};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, "w1_w2"};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, "w2_w1"};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, "w1_w2_b"};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, "w2_w1_b"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, "short_w1"};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, "after_short"};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, "long_w3"};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, "w3_w1"};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, "to_w2"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, "stop_w2"};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, "hold1_stop"};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, "hold2"};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, "hold3"};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, "hold4"};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, "hold5"};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, "qd_resume"};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, "resume_w2"};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, "qd_ignored"};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, "to_w2_c"};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, "to_w3"};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, "stop_w3"};

        // Reset state while CLR is held low
        clear_in();
        #12;
        chk_all("reset", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        @(posedge T3);
        CLR = 1'b1;

        // Beat sequencing table
        for (int i = 0; i < NVEC; i++) begin
            bus.QD    = vecs[i].qd;
            bus.SHORT = vecs[i].shrt;
            bus.LONG  = vecs[i].lng;
            bus.STOP  = vecs[i].stp;
            tick();
            chk_all(vecs[i].name, vecs[i].w, vecs[i].run, 1'b1, 1'b0, 1'b0, 3'd0);
        end
        clear_in();

`ifdef HD_BEAT_INT_EN
        // Request latency: pending after SYNC_STAGES+1 = 3 edges
        bus.PULSE = 1'b1;
        tick(); chk("pend_e1", {31'd0, bus.INT_PEND}, 32'd0);
        tick(); chk("pend_e2", {31'd0, bus.INT_PEND}, 32'd0);
        tick(); chk("pend_e3", {31'd0, bus.INT_PEND}, 32'd1);

        bus.QD = 1'b1;
        tick(); bus.QD = 1'b0;
        chk_all("int_qd", 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick(); chk_all("int_w2", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick(); chk_all("accept", 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);

        // SHORT makes every edge a boundary
        bus.PULSE = 1'b0;
        bus.SHORT = 1'b1;
        tick(); chk_all("save2", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        tick(); chk_all("save3", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
        bus.PULSE = 1'b1;   // new request while EI=0
        tick(); chk_all("save0", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        bus.IRET = 1'b1;
        tick(); bus.IRET = 1'b0;
        chk_all("iret4", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
        tick(); chk_all("iret5", 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
        tick(); chk_all("iret0", 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        tick(); chk_all("late_accept", 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);

        // Walk to INT_STEP=2 in W3, then reset asynchronously mid-cycle
        bus.PULSE = 1'b0;
        bus.SHORT = 1'b0;
        bus.LONG  = 1'b1;
        tick(); chk_all("s1_w2", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        tick(); chk_all("s1_w3", 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        tick(); chk_all("s2_w1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        tick();
        tick(); chk_all("s2_w3", 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
        #2 CLR = 1'b0;
        #1 chk_all("clr_async", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        clear_in();
        @(posedge T3);
        CLR = 1'b1;

        // EI strobes: clear wins over set; request latched meanwhile
        bus.PULSE  = 1'b1;
        bus.EI_CLR = 1'b1;
        tick(); chk("ei_clr", {31'd0, bus.EI}, 32'd0);
        bus.EI_CLR = 1'b0; bus.EI_SET = 1'b1;
        tick(); chk("ei_set", {31'd0, bus.EI}, 32'd1);
        bus.EI_CLR = 1'b1;
        tick(); chk("ei_both", {31'd0, bus.EI}, 32'd0);
        bus.EI_CLR = 1'b0;
        tick(); chk_all("ei_reset", 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        bus.EI_SET = 1'b0;

        // Accept and IRET at the same boundary: accept wins
        bus.QD = 1'b1;
        tick(); bus.QD = 1'b0;
        bus.SHORT = 1'b1;
        bus.IRET  = 1'b1;
        tick(); bus.IRET = 1'b0;
        chk_all("collide", 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        // Without RUN_MODE there is no boundary
        bus.RUN_MODE = 1'b0;
        tick(); chk_all("no_runmode", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        bus.RUN_MODE = 1'b1;
        tick(); chk_all("runmode_back", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
`else
        // Interrupt logic absent: strobes and requests have no effect
        bus.PULSE  = 1'b1;
        bus.EI_CLR = 1'b1;
        bus.IRET   = 1'b1;
        bus.QD     = 1'b1;
        tick();
        bus.QD   = 1'b0;
        bus.LONG = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("tied_pend_%0d", i), {31'd0, bus.INT_PEND}, 32'd0);
            chk($sformatf("tied_inta_%0d", i), {31'd0, bus.INTA}, 32'd0);
            chk($sformatf("tied_step_%0d", i), {29'd0, bus.INT_STEP}, 32'd0);
            chk($sformatf("tied_ei_%0d", i), {31'd0, bus.EI}, 32'd1);
        end
        chk_all("w3_noint", 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        #2 CLR = 1'b0;
        #1 chk_all("clr_async", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        clear_in();
        @(posedge T3);
        CLR = 1'b1;
        tick(); chk_all("after_clr", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
